// File: rtl/fp_round_pipe.sv
// fp_round_pipe: two-stage IEEE-754 rounding stage with valid/ready flow control.
// Stage 1 captures the operand and resolves the round-up decision; stage 2
// applies the increment, propagates mantissa carry into the exponent and
// saturates to infinity on overflow. Both stages hold a valid bit and advance
// only when the stage ahead of them is free or draining in the same cycle.
module fp_round_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int EXT_W = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sign,
    input  logic [EXP_W-1:0]         in_exp,
    input  logic [MAN_W-1:0]         in_man,
    input  logic [EXT_W-1:0]         in_ext,
    input  logic [1:0]               in_rmode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_fp,
    output logic                     out_inexact,
    output logic                     out_ovf
);

    typedef enum logic [1:0] {
        RM_RNE = 2'd0,
        RM_RTZ = 2'd1,
        RM_RUP = 2'd2,
        RM_RDN = 2'd3
    } rmode_e;

    // Stage 1 state
    logic                 s1_valid;
    logic                 s1_sign;
    logic [EXP_W-1:0]     s1_exp;
    logic [MAN_W-1:0]     s1_man;
    logic                 s1_inc;
    logic                 s1_inexact;
    logic                 s1_special;

    // Stage 2 valid; its data lives directly in the output registers
    logic                 s2_valid;

    // Flow control
    logic                 s1_adv;
    logic                 in_fire;

    // Stage 1 combinational decode
    logic                 guard;
    logic                 sticky;
    logic                 special_in;
    logic                 inc_raw;
    rmode_e               rmode;

    // Stage 2 combinational datapath
    logic [MAN_W:0]       man_sum;
    logic [EXP_W-1:0]     new_exp;
    logic                 new_ovf;
    logic [MAN_W-1:0]     new_man;

    assign s1_adv    = ~s2_valid | out_ready;
    assign in_ready  = ~s1_valid | s1_adv;
    assign in_fire   = in_valid & in_ready;
    assign out_valid = s2_valid;

    assign guard      = in_ext[EXT_W-1];
    assign sticky     = |in_ext[EXT_W-2:0];
    assign special_in = &in_exp;
    assign rmode      = rmode_e'(in_rmode);

    // Round-up decision for the incoming beat
    always_comb begin
        inc_raw = 1'b0;
        case (rmode)
            RM_RNE: inc_raw = guard & (sticky | in_man[0]);
            RM_RTZ: inc_raw = 1'b0;
            RM_RUP: inc_raw = ~in_sign & (guard | sticky);
            RM_RDN: inc_raw = in_sign & (guard | sticky);
            default: inc_raw = 1'b0;
        endcase
    end

    // Stage 1 register: operand plus pre-decoded increment and flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_exp     <= '0;
            s1_man     <= '0;
            s1_inc     <= 1'b0;
            s1_inexact <= 1'b0;
            s1_special <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign    <= in_sign;
                s1_exp     <= in_exp;
                s1_man     <= in_man;
                s1_inc     <= inc_raw & ~special_in;
                s1_inexact <= (guard | sticky) & ~special_in;
                s1_special <= special_in;
            end
        end
    end

    // Apply increment; a mantissa carry bumps the exponent and clears the fraction.
    // Specials carry inc=0, so they reach the output unchanged.
    always_comb begin
        man_sum = {1'b0, s1_man} + {{MAN_W{1'b0}}, s1_inc};
        new_exp = s1_exp + {{(EXP_W-1){1'b0}}, man_sum[MAN_W]};
        new_ovf = ~s1_special & (&new_exp);
        new_man = (man_sum[MAN_W] | new_ovf) ? '0 : man_sum[MAN_W-1:0];
    end

    // Stage 2 register: result held stable while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid    <= 1'b0;
            out_fp      <= '0;
            out_inexact <= 1'b0;
            out_ovf     <= 1'b0;
        end else if (s1_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_fp      <= {s1_sign, new_exp, new_man};
                out_inexact <= s1_inexact;
                out_ovf     <= new_ovf;
            end
        end
    end

endmodule

// File: tb/tb_fp_round_pipe.sv
// Scoreboard bench for fp_round_pipe: expected results are queued on accept
// and compared whenever the DUT presents a valid result.
module tb_fp_round_pipe;

    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int EXT_W = 10;
    localparam int FP_W  = 1 + EXP_W + MAN_W;

    typedef struct {
        logic [FP_W-1:0] fp;
        logic            inx;
        logic            ovf;
        bit              lat;
        int              acc;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic                 in_sign = 1'b0;
    logic [EXP_W-1:0]     in_exp = '0;
    logic [MAN_W-1:0]     in_man = '0;
    logic [EXT_W-1:0]     in_ext = '0;
    logic [1:0]           in_rmode = 2'd0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [FP_W-1:0]      out_fp;
    logic                 out_inexact;
    logic                 out_ovf;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_pop = 0;
    exp_t q[$];

    fp_round_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .EXT_W(EXT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_man(in_man),
        .in_ext(in_ext), .in_rmode(in_rmode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_fp(out_fp), .out_inexact(out_inexact), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, want);
        end
    endtask

    // Reference: treat {exp,man} as one integer so a fraction carry ripples into the exponent
    function automatic logic [FP_W+1:0] model(input logic sg, input logic [EXP_W-1:0] e,
                                              input logic [MAN_W-1:0] m, input logic [EXT_W-1:0] x,
                                              input logic [1:0] rm);
        logic g, s, inc, ovf;
        int unsigned v, ex;
        logic [EXP_W+MAN_W-1:0] mag;
        g = x[EXT_W-1];
        s = |x[EXT_W-2:0];
        if (&e) return {sg, e, m, 2'b00};
        case (rm)
            2'd0: inc = g & (s | m[0]);
            2'd1: inc = 1'b0;
            2'd2: inc = ~sg & (g | s);
            default: inc = sg & (g | s);
        endcase
        v = int'({e, m}) + int'(inc);
        ex = v >> MAN_W;
        ovf = (ex == (1 << EXP_W) - 1);
        if (ovf) v = ex << MAN_W;
        mag = v[EXP_W+MAN_W-1:0];
        return {sg, mag, g | s, ovf};
    endfunction

    // Scoreboard compare; a held result is re-checked every stalled cycle
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_out", 32'd1, 32'd0);
            end else begin
                chk("out_fp", 32'(out_fp), 32'(q[0].fp));
                chk("out_inexact", 32'(out_inexact), 32'(q[0].inx));
                chk("out_ovf", 32'(out_ovf), 32'(q[0].ovf));
                if (out_ready) begin
                    if (q[0].lat) chk("latency", 32'(cyc - q[0].acc), 32'd2);
                    last_pop = cyc;
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic wait_accept(input logic [FP_W-1:0] efp, input logic einx, input logic eovf, input bit lat);
        int n = 0;
        bit done = 0;
        exp_t e;
        while (!done) begin
            @(negedge clk);
            if (in_ready && !rst) begin
                e.fp = efp; e.inx = einx; e.ovf = eovf; e.lat = lat; e.acc = cyc;
                q.push_back(e);
                done = 1;
            end else if (++n > 50) begin
                chk("accept_timeout", 32'd0, 32'd1);
                done = 1;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drive(input logic sg, input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m,
                         input logic [EXT_W-1:0] x, input logic [1:0] rm);
        in_valid = 1'b1; in_sign = sg; in_exp = e; in_man = m; in_ext = x; in_rmode = rm;
    endtask

    task automatic send(input logic sg, input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m,
                        input logic [EXT_W-1:0] x, input logic [1:0] rm,
                        input logic [FP_W-1:0] efp, input logic einx, input logic eovf, input bit lat);
        drive(sg, e, m, x, rm);
        wait_accept(efp, einx, eovf, lat);
    endtask

    task automatic send_model(input logic sg, input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m,
                              input logic [EXT_W-1:0] x, input logic [1:0] rm, input bit lat);
        logic [FP_W+1:0] r;
        r = model(sg, e, m, x, rm);
        send(sg, e, m, x, rm, r[FP_W+1:2], r[1], r[0], lat);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int rel;
        logic [FP_W+1:0] r2;

        // Reset state while rst is held
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_fp", 32'(out_fp), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        send(1'b0, 5'h0F, 10'h3FF, 10'h200, 2'd0, 16'h4000, 1'b1, 1'b0, 1'b1);
        send(1'b0, 5'h0F, 10'h000, 10'h200, 2'd0, 16'h3C00, 1'b1, 1'b0, 1'b1);
        send(1'b0, 5'h0F, 10'h000, 10'h3FF, 2'd1, 16'h3C00, 1'b1, 1'b0, 1'b1);
        send(1'b0, 5'h0F, 10'h000, 10'h000, 2'd0, 16'h3C00, 1'b0, 1'b0, 1'b1);
        send(1'b1, 5'h0F, 10'h001, 10'h001, 2'd3, 16'hBC02, 1'b1, 1'b0, 1'b1);
        send(1'b1, 5'h0F, 10'h001, 10'h001, 2'd2, 16'hBC01, 1'b1, 1'b0, 1'b1);
        send(1'b1, 5'h0F, 10'h001, 10'h001, 2'd0, 16'hBC01, 1'b1, 1'b0, 1'b1);
        send(1'b0, 5'h1E, 10'h3FF, 10'h300, 2'd0, 16'h7C00, 1'b1, 1'b1, 1'b1);
        send(1'b0, 5'h1F, 10'h201, 10'h3FF, 2'd2, 16'h7E01, 1'b0, 1'b0, 1'b1);
        send(1'b1, 5'h1E, 10'h3FF, 10'h001, 2'd3, 16'hFC00, 1'b1, 1'b1, 1'b1);
        send(1'b0, 5'h00, 10'h3FF, 10'h200, 2'd0, 16'h0400, 1'b1, 1'b0, 1'b1);
        drain();

        // Back-to-back random stream at full throughput
        for (int i = 0; i < 40; i++)
            send_model(1'($urandom), 5'($urandom_range(0, 31)), 10'($urandom),
                       10'($urandom), 2'($urandom), 1'b1);
        drain();

        // Backpressure: two beats fill the pipe, the third must wait
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++)
            send_model(1'($urandom), 5'($urandom_range(0, 30)), 10'($urandom),
                       10'($urandom), 2'($urandom), 1'b0);
        drive(1'b0, 5'h10, 10'h155, 10'h2AA, 2'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        rel = cyc;
        r2 = model(1'b0, 5'h10, 10'h155, 10'h2AA, 2'd0);
        wait_accept(r2[FP_W+1:2], r2[1], r2[0], 1'b0);
        send_model(1'b1, 5'h08, 10'h2FF, 10'h3FF, 2'd3, 1'b0);
        drain();
        chk("drain_no_gap", 32'(last_pop - rel), 32'd3);

        // Asynchronous reset with two beats in flight
        send_model(1'b0, 5'h05, 10'h0AA, 10'h1FF, 2'd2, 1'b0);
        send_model(1'b1, 5'h06, 10'h0BB, 10'h200, 2'd0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_fp", 32'(out_fp), 32'd0);
        chk("arst_out_inexact", 32'(out_inexact), 32'd0);
        chk("arst_out_ovf", 32'(out_ovf), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        q.delete();
        @(posedge clk); #3;
        rst = 1'b0;
        send(1'b0, 5'h0F, 10'h3FF, 10'h200, 2'd0, 16'h4000, 1'b1, 1'b0, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_round_pipe.md
# fp_round_pipe

Parametrised, pipelined floating-point rounding stage for the MAC datapath. It takes a normalised sign/exponent/mantissa and the extra low-order bits that the normaliser produces, then applies one of four IEEE-754 rounding modes. It handles mantissa carry into the exponent and overflow to infinity, and returns the packed result with inexact and overflow flags. The block sits between the normalise stage and the MAC output register, and uses valid/ready flow control so it can be stalled.

## Interface
- EXP_W, 5, exponent width
- MAN_W, 10, stored mantissa (fraction) width, no hidden bit
- EXT_W, 10, extension bits below the mantissa LSB (EXT_W ≥ 2)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_sign  in  1  sign
- in_exp  in  EXP_W  biased exponent
- in_man  in  MAN_W  fraction to be rounded
- in_ext  in  EXT_W  discarded low bits; MSB is the guard bit, the rest are OR-ed into sticky
- in_rmode  in  2  0=RNE (nearest-even), 1=RTZ, 2=RUP (+inf), 3=RDN (−inf); sampled with the beat
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_fp  out  1+EXP_W+MAN_W  packed {sign, exp, man}
- out_inexact  out  1  guard or sticky was nonzero (non-special input)
- out_ovf  out  1  rounding carried the exponent to all-ones

## Operation
- Definitions: g = in_ext[EXT_W-1]; s = |in_ext[EXT_W-2:0]; lsb = in_man[0].
- Increment decision (inc):
  - RNE: g & (s | lsb)
  - RTZ: 0
  - RUP: ~sign & (g | s)
  - RDN: sign & (g | s)
- Stage 1 registers sign, exp, man, inc, inexact = g|s, and special = (exp == all-ones).
- Stage 2 computes {c, m} = man + inc as (MAN_W+1) bits:
  - c=0: exp is unchanged, man = m.
  - c=1: man = 0, exp = exp+1.
  - If the new exp == all-ones: result is ±inf (man = 0) and out_ovf = 1.
- Special inputs (exp all-ones, i.e. inf/NaN) pass through bit-exact, with inc forced to 0, inexact = 0 and ovf = 0.
- Zero and subnormal inputs (exp = 0) round the same as normal values. A carry out of a subnormal fraction sets exp = 1, which is correct IEEE behaviour.
- No rounding mode ever produces a largest-finite result. Overflow only arises from an increment, so it always saturates to infinity.
- Each stage holds a valid bit. A stage loads when it is empty or when its contents advance in the same cycle.
- Backpressure:
  - in_ready = ~s1_valid | s1_adv
  - s1_adv = ~s2_valid | out_ready
- Ordering is preserved. No beat is dropped or duplicated.

## Timing
- Latency is 2 cycles from an accepted input (in_valid & in_ready at edge N) to out_valid at edge N+2, when out_ready is held high.
- Throughput is 1 beat per clock with no stalls.
- With out_ready low, at most 2 beats are buffered (one per stage). in_ready deasserts in the same cycle the second beat would be blocked.
- out_fp, out_inexact and out_ovf are registered. They stay stable while out_valid & ~out_ready.
- in_ready depends combinationally on out_ready. There is no combinational path from in_* data to out_*.
- Reset:
  - Asserting rst clears both valid bits immediately, regardless of any pending beats.
  - out_valid = 0, out_fp = 0, out_inexact = 0, out_ovf = 0.
  - in_ready = 1 while rst is high and after release.
  - In-flight beats are discarded.
- A simultaneous accept and emit in the same cycle is legal. The stages shift and the count is unchanged.

## Test plan
All values use default parameters (FP16, EXT_W=10); results are shown as out_fp hex.
- **RNE carry:** sign 0, exp 0x0F, man 0x3FF, ext 0x200, rmode 0 -> 0x4000, inexact=1, ovf=0, out_valid exactly 2 cycles after accept.
- **RNE tie-to-even and RTZ:**
  - man 0x000, exp 0x0F, ext 0x200, RNE -> 0x3C00, inexact=1.
  - Same operand with ext 0x3FF, RTZ -> 0x3C00.
  - ext 0x000 -> inexact=0.
- **Directed modes:** sign 1, exp 0x0F, man 0x001, ext 0x001:
  - RDN -> 0xBC02.
  - RUP -> 0xBC01.
  - RNE -> 0xBC01.
- **Overflow and specials:**
  - exp 0x1E, man 0x3FF, ext 0x300, RNE -> 0x7C00, ovf=1, inexact=1.
  - Input 0x7E01 (NaN) with ext 0x3FF, RUP -> 0x7E01, flags 0.
- **Backpressure:**
  - Hold out_ready=0 and offer 4 consecutive beats -> only 2 are accepted and in_ready falls.
  - Release out_ready -> 4 results emerge in order with no gaps or duplicates, and out_fp stays stable during the stall.
- **Reset mid-stream:**
  - Assert rst asynchronously (off a clock edge) with 2 beats in flight -> out_valid drops before the next edge, outputs are 0, and in_ready=1.
  - After release, a new beat emerges 2 cycles after accept with the correct value.
